// File: rtl/dpram_access_ctrl.sv
// rtl/dpram_access_ctrl.sv - two-client scheduler for the 32Kx4 dual-port RAM
// Optional conflict counter port enabled by DPRAM_CTRL_STATS_EN.
module dpram_access_ctrl #(
  parameter int AW         = 15,
  parameter int DW         = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  input  logic          c2_req,
  input  logic          c2_we,
  input  logic [AW-1:0] c2_addr,
  input  logic [DW-1:0] c2_wdata,
  output logic          c1_ack,
  output logic          c2_ack,
  output logic          c1_rvalid,
  output logic          c2_rvalid,
  output logic [DW-1:0] c1_rdata,
  output logic [DW-1:0] c2_rdata,
  output logic          ram_rw_1,
  output logic          ram_rw_2,
  output logic [AW-1:0] ram_addr_1,
  output logic [AW-1:0] ram_addr_2,
  output logic [DW-1:0] ram_din_1,
  output logic [DW-1:0] ram_din_2,
  input  logic [DW-1:0] ram_dout_1,
  input  logic [DW-1:0] ram_dout_2
`ifdef DPRAM_CTRL_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] ADDR_LSB = AW'(1);

  typedef enum logic {P1_PRI, P2_PRI} pri_e;

  pri_e          pri_q;
  logic [SW-1:0] starve_q;
  logic          same_addr, conflict, bcast, iss1, iss2;
  logic          rd1_pend_q, rd2_pend_q, rd2_src_q;

  always_comb begin
    same_addr = c1_req & c2_req & (c1_addr == c2_addr);
    conflict  = same_addr & (c1_we | c2_we);
    bcast     = same_addr & ~c1_we & ~c2_we;
    c1_ack    = ~rst & c1_req & ~(conflict & (pri_q == P2_PRI));
    c2_ack    = ~rst & c2_req & ~(conflict & (pri_q == P1_PRI));
    iss1      = c1_ack;
    // a broadcast read is served by port 1 alone
    iss2      = c2_ack & ~bcast;
  end

  // Unissued ports are parked on the neighbour address so the ports never collide.
  always_comb begin
    ram_rw_1   = 1'b0;
    ram_rw_2   = 1'b0;
    ram_din_1  = '0;
    ram_din_2  = '0;
    ram_addr_1 = c1_addr;
    ram_addr_2 = c1_addr ^ ADDR_LSB;
    if (iss1) begin
      ram_rw_1   = c1_we;
      ram_din_1  = c1_wdata;
      ram_addr_1 = c1_addr;
    end
    if (iss2) begin
      ram_rw_2   = c2_we;
      ram_din_2  = c2_wdata;
      ram_addr_2 = c2_addr;
      if (!iss1) ram_addr_1 = c2_addr ^ ADDR_LSB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q    <= P1_PRI;
      starve_q <= '0;
    end else begin
      case (pri_q)
        P1_PRI: begin
          if (conflict) begin
            if (starve_q == SW'(STARVE_MAX - 1)) pri_q <= P2_PRI;
            starve_q <= starve_q + 1'b1;
          end else if (c2_ack) begin
            starve_q <= '0;
          end
        end
        P2_PRI: begin
          if (c2_ack) begin
            pri_q    <= P1_PRI;
            starve_q <= '0;
          end
        end
        default: pri_q <= P1_PRI;
      endcase
    end
  end

  // Read data arrives one cycle after the RAM latches the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_pend_q <= 1'b0;
      rd2_pend_q <= 1'b0;
      rd2_src_q  <= 1'b0;
      c1_rvalid  <= 1'b0;
      c2_rvalid  <= 1'b0;
      c1_rdata   <= '0;
      c2_rdata   <= '0;
    end else begin
      rd1_pend_q <= c1_ack & ~c1_we;
      rd2_pend_q <= c2_ack & ~c2_we;
      rd2_src_q  <= bcast;
      c1_rvalid  <= rd1_pend_q;
      c2_rvalid  <= rd2_pend_q;
      if (rd1_pend_q) c1_rdata <= ram_dout_1;
      if (rd2_pend_q) c2_rdata <= rd2_src_q ? ram_dout_1 : ram_dout_2;
    end
  end

`ifdef DPRAM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
